// File: rtl/serial_mag_comparator_pkg.sv
// Shared types and constants for the serial magnitude comparator.
// The CMP_EARLY_EXIT_EN build option is consumed in serial_mag_comparator.sv.
package serial_cmp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int SLICE_W = 2;

   // One-hot verdicts {gt, eq, lt}; all-zero means no unequal slice seen yet
   localparam logic [2:0] GT        = 3'b100;
   localparam logic [2:0] EQ        = 3'b010;
   localparam logic [2:0] LT        = 3'b001;
   localparam logic [2:0] UNDECIDED = 3'b000;

   function automatic logic [2:0] resolveVerdict(input logic [2:0] verdict);
      return (verdict == UNDECIDED) ? EQ : verdict;
   endfunction

endpackage

// File: rtl/serial_mag_comparator_slice.sv
// Combinational 2-bit magnitude comparator used as the per-step slice.
module comparator_2bit
   import serial_cmp_pkg::*;
(
   input  logic [SLICE_W-1:0] a_i,
   input  logic [SLICE_W-1:0] b_i,
   output logic               gt_o,
   output logic               eq_o,
   output logic               lt_o
);

   always_comb begin
      gt_o = (a_i > b_i);
      eq_o = (a_i == b_i);
      lt_o = (a_i < b_i);
   end

endmodule

// File: rtl/serial_mag_comparator.sv
// Serial unsigned magnitude comparator, two bits per cycle, MSB pair first.
// Define CMP_EARLY_EXIT_EN to finish on the first unequal slice.
module serial_mag_comparator
   import serial_cmp_pkg::*;
#(
   parameter int WIDTH = 8
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             a_gt_b,
   output logic             a_eq_b,
   output logic             a_lt_b,
   output logic             busy
);

   localparam int STEPS = WIDTH / SLICE_W;
   localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEPS - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] aSh_q, aSh_d;
   logic [WIDTH-1:0] bSh_q, bSh_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       verdict_q, verdict_d;
   logic [2:0]       res_q, res_d;

   logic             sliceGt, sliceEq, sliceLt;
   logic [2:0]       sliceRes;
   logic             finish;

   comparator_2bit uSlice (
      .a_i  (aSh_q[WIDTH-1 -: SLICE_W]),
      .b_i  (bSh_q[WIDTH-1 -: SLICE_W]),
      .gt_o (sliceGt),
      .eq_o (sliceEq),
      .lt_o (sliceLt)
   );

   assign sliceRes = {sliceGt, sliceEq, sliceLt};

   always_comb begin
      state_d   = state_q;
      aSh_d     = aSh_q;
      bSh_d     = bSh_q;
      cnt_d     = cnt_q;
      verdict_d = verdict_q;
      res_d     = res_q;
      finish    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_valid) begin
               aSh_d     = a;
               bSh_d     = b;
               cnt_d     = CNT_LOAD;
               verdict_d = UNDECIDED;
               state_d   = RUN;
            end
         end
         RUN: begin
            aSh_d = aSh_q << SLICE_W;
            bSh_d = bSh_q << SLICE_W;
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end
            // First unequal slice wins; less significant slices cannot override it
            if (verdict_q == UNDECIDED && sliceRes != EQ) begin
               verdict_d = sliceRes;
            end
`ifdef CMP_EARLY_EXIT_EN
            finish = (cnt_q == '0) || (verdict_d != UNDECIDED);
`else
            finish = (cnt_q == '0);
`endif
            if (finish) begin
               res_d   = resolveVerdict(verdict_d);
               state_d = DONE;
            end
         end
         DONE: begin
            if (res_ready) begin
               res_d   = UNDECIDED;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         aSh_q     <= '0;
         bSh_q     <= '0;
         cnt_q     <= '0;
         verdict_q <= UNDECIDED;
         res_q     <= UNDECIDED;
      end else begin
         state_q   <= state_d;
         aSh_q     <= aSh_d;
         bSh_q     <= bSh_d;
         cnt_q     <= cnt_d;
         verdict_q <= verdict_d;
         res_q     <= res_d;
      end
   end

   // Gating with rst_n keeps every output quiet while reset is held
   always_comb begin
      start_ready = rst_n && (state_q == IDLE);
      res_valid   = rst_n && (state_q == DONE);
      busy        = rst_n && (state_q != IDLE);
      a_gt_b      = res_valid && res_q[2];
      a_eq_b      = res_valid && res_q[1];
      a_lt_b      = res_valid && res_q[0];
   end

endmodule

// File: doc/serial_mag_comparator.md
SERIAL_MAG_COMPARATOR -- requirements
Module: serial_mag_comparator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal values are even and at least 2.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, reset; reset is synchronous and active-low.
REQ-004 The block SHALL have port start_valid, input, 1 bit, signalling that the operands are valid.
REQ-005 The block SHALL have port start_ready, output, 1 bit, signalling that the block can accept operands.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each, unsigned operands, sampled on the start handshake.
REQ-007 The block SHALL have port res_valid, output, 1 bit, signalling that the result is valid.
REQ-008 The block SHALL have port res_ready, input, 1 bit, signalling that the consumer accepts the result.
REQ-009 The block SHALL have ports a_gt_b, a_eq_b and a_lt_b, output, 1 bit each, the registered result flags.
REQ-010 The block SHALL have port busy, output, 1 bit, high whenever state is not IDLE.

Function
REQ-011 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-012 In IDLE, start_ready SHALL be 1; in RUN and DONE, start_ready SHALL be 0.
REQ-013 An accept SHALL occur when start_valid and start_ready are both high at a rising edge.
  - The block latches a and b into shift registers.
  - The step counter loads WIDTH/2-1.
  - State goes to RUN.
REQ-014 In each RUN cycle, the block SHALL compare the top 2 bits of both shift registers with one comparator_2bit slice, MSB pair first.
  - Both shift registers then shift left by 2.
  - The counter decrements.
REQ-015 On the first slice with gt or lt, that verdict SHALL be captured in a sticky register; later slices cannot change it.
REQ-016 If every slice is equal, the result SHALL be eq.
REQ-017 Default latency: after an accept at edge k, res_valid SHALL rise after edge k+WIDTH/2, independent of the data.
REQ-018 In DONE, res_valid SHALL be 1 and exactly one of gt/eq/lt SHALL be 1.
  - The flags hold stable until res_valid and res_ready are both high.
  - State then goes to IDLE.
REQ-019 While res_valid is 0, all three result flags SHALL be driven to 0.
REQ-020 In DONE, start_valid SHALL be ignored.
  - If res_ready is high, an accept is possible no earlier than the following cycle.
  - There is no same-cycle restart.
REQ-021 Operand changes on a or b after an accept SHALL have no effect on the operation in progress.
REQ-022 Counter reaching 0 in RUN SHALL cause the transition to DONE on that edge; the counter never wraps.

Reset
REQ-023 With rst_n low at a rising edge, the block SHALL apply reset values.
  - State goes to IDLE.
  - Shift registers, counter and sticky verdict clear.
  - res_valid, the result flags and busy are 0.
REQ-024 start_ready SHALL be 0 while rst_n is low and 1 from the first cycle after release.
REQ-025 Reset asserted in RUN or DONE SHALL abort the operation.
  - The pending result is discarded.
  - No res_valid pulse is produced.

Configuration
REQ-026 The macro CMP_EARLY_EXIT_EN SHALL control early termination.
  - Defined: RUN goes to DONE on the edge that evaluates the first unequal slice.
  - Latency is m cycles, where m is the 1-based index of that slice from the MSB, or WIDTH/2 if all slices are equal.
  - Undefined: latency is always WIDTH/2, as in REQ-017.
REQ-027 Result values SHALL be identical with and without CMP_EARLY_EXIT_EN; only latency differs.

Structure
REQ-028 The package serial_cmp_pkg SHALL hold:
  - the state enum typedef (IDLE/RUN/DONE);
  - the result encoding localparams (GT, EQ, LT one-hot);
  - the slice width constant SLICE_W=2.
REQ-029 The block SHALL instantiate exactly one comparator_2bit as its per-step slice sub-module; there is no other sub-module.

Verification (WIDTH=8 unless stated)
REQ-030 Equal operands: a=8'hA5, b=8'hA5 -> eq=1 after 4 cycles in both builds.
REQ-031 MSB decides: a=8'h80, b=8'h7F -> gt=1 after 1 cycle with CMP_EARLY_EXIT_EN, after 4 cycles without.
REQ-032 LSB decides: a=8'h12, b=8'h13 -> lt=1 after 4 cycles in both builds.
REQ-033 Backpressure: res_ready held at 0 for 5 cycles in DONE while start_valid=1 -> flags stable, start_ready=0, and no accept until after the result handshake.
REQ-034 Reset mid-operation: rst_n=0 during the second RUN cycle -> all outputs 0 and no res_valid; start_ready=1 the cycle after release; a fresh a=8'h01, b=8'h00 then gives gt.
REQ-035 Exhaustive check: WIDTH=4, all 256 operand pairs -> flags match an integer compare, are one-hot, and the latency rule holds.
